tx_frame_timer: RTL and testbench

//   Parametrised UART-Tx frame timer. A clock prescaler generates one bit

---
 rtl/tx_frame_timer.sv | 126 ++++++++++++
 tb/tb_tx_frame_timer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_timer.sv
// UART-Tx frame timer: bit-period prescaler plus bit counter with start/busy/done, pause, abort and continuous frames.
// Latency: busy rises at the start edge; first bit_tick comes clk_div+1 enabled clocks later, frame_done with the last tick.
// Backpressure: enable=0 freezes both counters and masks bit_tick/frame_done; start while busy is dropped, never queued.
module tx_frame_timer #(
    parameter int CW = 16,
    parameter int BW = 4
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          start,
    input  logic          abort,
    input  logic          enable,
    input  logic          cont,
    input  logic [CW-1:0] clk_div,
    input  logic [BW-1:0] num_bits,
    output logic          busy,
    output logic          bit_tick,
    output logic          frame_done,
    output logic [BW-1:0] bit_index
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_presc;
    logic [CW-1:0] w_presc_nxt;
    logic [CW-1:0] r_div_q;
    logic [CW-1:0] w_div_nxt;
    logic [BW-1:0] r_bit_idx;
    logic [BW-1:0] w_bit_idx_nxt;
    logic [BW-1:0] r_bits_q;
    logic [BW-1:0] w_bits_nxt;

    logic w_run;
    logic w_period_end;
    logic w_last_bit;
    logic w_tick;

    // Counters only ever wrap by comparing against the latched maximum, so
    // all-ones settings give the full 2^CW clocks per bit and 2^BW bits.
    assign w_run        = (r_state == S_RUN);
    assign w_period_end = (r_presc == r_div_q);
    assign w_last_bit   = (r_bit_idx == r_bits_q);
    assign w_tick       = w_run & enable & ~abort & w_period_end;

    assign busy       = w_run;
    assign bit_tick   = w_tick;
    assign frame_done = w_tick & w_last_bit;
    assign bit_index  = r_bit_idx;

    // State and counter registers; reset drops straight back to idle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_div_q   <= '0;
            r_bit_idx <= '0;
            r_bits_q  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_presc   <= w_presc_nxt;
            r_div_q   <= w_div_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_bits_q  <= w_bits_nxt;
        end
    end

    // Next-state: abort wins over everything, then start in idle, then counting.
    always_comb begin
        w_state_nxt   = r_state;
        w_presc_nxt   = r_presc;
        w_div_nxt     = r_div_q;
        w_bit_idx_nxt = r_bit_idx;
        w_bits_nxt    = r_bits_q;

        if (abort) begin
            w_state_nxt   = S_IDLE;
            w_presc_nxt   = '0;
            w_bit_idx_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Start is accepted even while paused; the first bit
                    // simply waits for enable.
                    if (start) begin
                        w_state_nxt   = S_RUN;
                        w_div_nxt     = clk_div;
                        w_bits_nxt    = num_bits;
                        w_presc_nxt   = '0;
                        w_bit_idx_nxt = '0;
                    end
                end
                S_RUN: begin
                    if (enable) begin
                        if (w_period_end) begin
                            w_presc_nxt = '0;
                            if (w_last_bit) begin
                                w_bit_idx_nxt = '0;
                                // Continuous mode rolls straight into the next
                                // frame with freshly latched settings, no gap.
                                if (cont) begin
                                    w_div_nxt  = clk_div;
                                    w_bits_nxt = num_bits;
                                end else begin
                                    w_state_nxt = S_IDLE;
                                end
                            end else begin
                                w_bit_idx_nxt = r_bit_idx + 1'b1;
                            end
                        end else begin
                            w_presc_nxt = r_presc + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_timer.sv
// Testbench for tx_frame_timer: table of frame settings plus hand-written corner sequences.
// Expected bit_tick events are queued when a frame is started and popped by a negedge monitor.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge or after that change.
module tb_tx_frame_timer;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        enable = 1'b1;
    logic        cont = 1'b0;
    logic [15:0] clk_div = '0;
    logic [3:0]  num_bits = '0;
    logic        busy;
    logic        bit_tick;
    logic        frame_done;
    logic [3:0]  bit_index;

    logic        start4 = 1'b0;
    logic [3:0]  clk_div4 = 4'd15;
    logic [3:0]  num_bits4 = 4'd15;
    logic        busy4;
    logic        tick4;
    logic        done4;
    logic [3:0]  idx4;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        int         t;
        logic [3:0] idx;
        logic       done;
    } ev_t;
    ev_t exp_q[$];

    typedef struct {
        logic [15:0] div;
        logic [3:0]  nb;
        int          exp_len;
    } vec_t;
    vec_t vecs[6];

    tx_frame_timer #(.CW(16), .BW(4)) u_dut (
        .clk(clk), .nrst(nrst), .start(start), .abort(abort),
        .enable(enable), .cont(cont), .clk_div(clk_div), .num_bits(num_bits),
        .busy(busy), .bit_tick(bit_tick), .frame_done(frame_done),
        .bit_index(bit_index)
    );

    tx_frame_timer #(.CW(4), .BW(4)) u_dut4 (
        .clk(clk), .nrst(nrst), .start(start4), .abort(1'b0),
        .enable(1'b1), .cont(1'b0), .clk_div(clk_div4), .num_bits(num_bits4),
        .busy(busy4), .bit_tick(tick4), .frame_done(done4),
        .bit_index(idx4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every tick must match the head of the expected queue.
    always @(negedge clk) begin
        if (bit_tick) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_tick: got tick at cycle %0d expected none", cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("tick_cycle", cyc, e.t);
                check("tick_index", {28'd0, bit_index}, {28'd0, e.idx});
                check("tick_done", {31'd0, frame_done}, {31'd0, e.done});
            end
        end else if (frame_done) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_without_tick: got frame_done=1 expected 0 at cycle %0d", cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic wait_idle(input int bound, output int fall);
        int k = 0;
        while (busy && k < bound) begin
            step();
            k++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
        fall = cyc;
    endtask

    task automatic push_frame(input int e0, input int d, input int n, input int shift_from, input int shift);
        for (int b = 0; b <= n; b++) begin
            ev_t ev;
            ev.t    = e0 + (d + 1) * (b + 1) - 1 + ((b >= shift_from) ? shift : 0);
            ev.idx  = 4'(b);
            ev.done = (b == n);
            exp_q.push_back(ev);
        end
    endtask

    // Start one frame (assumes idle), measure busy length, drain scoreboard.
    task automatic run_vec(input logic [15:0] d, input logic [3:0] n, input int exp_len);
        int e0;
        int fall;
        step();
        clk_div  = d;
        num_bits = n;
        start    = 1'b1;
        e0       = cyc + 1;
        push_frame(e0, int'(d), int'(n), 99, 0);
        step();
        start = 1'b0;
        check("busy_rise", {31'd0, busy}, 32'd1);
        wait_idle(exp_len + 10, fall);
        check("frame_len", fall - e0, exp_len);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int fall;

        vecs[0] = '{div: 16'd3, nb: 4'd9,  exp_len: 40};
        vecs[1] = '{div: 16'd0, nb: 4'd0,  exp_len: 1};
        vecs[2] = '{div: 16'd1, nb: 4'd2,  exp_len: 6};
        vecs[3] = '{div: 16'd0, nb: 4'd15, exp_len: 16};
        vecs[4] = '{div: 16'd2, nb: 4'd4,  exp_len: 15};
        vecs[5] = '{div: 16'd4, nb: 4'd0,  exp_len: 5};

        // Reset state.
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_tick", {31'd0, bit_tick}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_index", {28'd0, bit_index}, 32'd0);
        step();
        nrst = 1'b1;
        step();

        // Table-driven frames.
        for (int i = 0; i < 6; i++) run_vec(vecs[i].div, vecs[i].nb, vecs[i].exp_len);

        // Pause for 5 clocks during bit 2.
        step();
        clk_div = 16'd3; num_bits = 4'd9; start = 1'b1;
        e0 = cyc + 1;
        push_frame(e0, 3, 9, 2, 5);
        step();
        start = 1'b0;
        wait_until(e0 + 9);
        enable = 1'b0;
        step(); step();
        check("pause_index", {28'd0, bit_index}, 32'd2);
        check("pause_no_tick", {31'd0, bit_tick}, 32'd0);
        wait_until(e0 + 14);
        enable = 1'b1;
        wait_idle(80, fall);
        check("pause_frame_len", fall - e0, 45);
        check("pause_queue_drained", exp_q.size(), 0);

        // Continuous frames with clk_div changed mid-frame.
        step();
        clk_div = 16'd3; num_bits = 4'd1; cont = 1'b1; start = 1'b1;
        e0 = cyc + 1;
        push_frame(e0, 3, 1, 99, 0);
        push_frame(e0 + 8, 1, 1, 99, 0);
        step();
        start = 1'b0;
        clk_div = 16'd1;
        wait_until(e0 + 8);
        check("cont_busy_boundary", {31'd0, busy}, 32'd1);
        check("cont_index_boundary", {28'd0, bit_index}, 32'd0);
        step();
        cont = 1'b0;
        wait_idle(40, fall);
        check("cont_total_len", fall - e0, 12);
        check("cont_queue_drained", exp_q.size(), 0);

        // Abort on the last clock of bit 4; stray start mid-frame is ignored.
        step();
        clk_div = 16'd3; num_bits = 4'd9; start = 1'b1;
        e0 = cyc + 1;
        push_frame(e0, 3, 3, 99, 0);
        exp_q[$].done = 1'b0;
        step();
        start = 1'b0;
        wait_until(e0 + 5);
        start = 1'b1; num_bits = 4'd2;
        step();
        start = 1'b0; num_bits = 4'd9;
        wait_until(e0 + 19);
        abort = 1'b1;
        @(negedge clk);
        check("abort_no_tick", {31'd0, bit_tick}, 32'd0);
        check("abort_no_done", {31'd0, frame_done}, 32'd0);
        step();
        abort = 1'b0;
        check("abort_idle", {31'd0, busy}, 32'd0);
        check("abort_index", {28'd0, bit_index}, 32'd0);
        check("abort_queue_drained", exp_q.size(), 0);
        abort = 1'b1; start = 1'b1;
        step();
        check("abort_start_idle", {31'd0, busy}, 32'd0);
        abort = 1'b0; start = 1'b0;
        step();
        check("abort_start_stays_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-frame, then a normal frame.
        step();
        clk_div = 16'd3; num_bits = 4'd9; start = 1'b1;
        e0 = cyc + 1;
        push_frame(e0, 3, 9, 99, 0);
        step();
        start = 1'b0;
        wait_until(e0 + 11);
        #1;
        nrst = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_tick", {31'd0, bit_tick}, 32'd0);
        check("arst_done", {31'd0, frame_done}, 32'd0);
        check("arst_index", {28'd0, bit_index}, 32'd0);
        exp_q.delete();
        step(); step();
        nrst = 1'b1;
        run_vec(16'd3, 4'd9, 40);

        // Narrow prescaler at maximum settings: 16 clocks per bit, 16 bits.
        begin
            int ticks = 0;
            int dones = 0;
            int first = -1;
            int k = 0;
            logic [3:0] done_idx = '0;
            step();
            start4 = 1'b1;
            e0 = cyc + 1;
            step();
            start4 = 1'b0;
            while (busy4 && k < 300) begin
                if (tick4) begin
                    ticks++;
                    if (first < 0) first = cyc;
                end
                if (done4) begin
                    dones++;
                    done_idx = idx4;
                end
                step();
                k++;
            end
            check("cw4_first_tick", first, e0 + 15);
            check("cw4_tick_count", ticks, 16);
            check("cw4_done_count", dones, 1);
            check("cw4_done_index", {28'd0, done_idx}, 32'd15);
            check("cw4_frame_len", cyc - e0, 256);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
